// File: rtl/cpeta_pipe.sv
`default_nettype none
// ============================================================================
// Module      : cpeta_pipe
// Description : Two-stage valid/ready pipelined adder with selectable exact
//               or approximate mode, per-result error flag and a saturating
//               count of erroneous delivered results.
// Revision    : 1.0 - initial release
// ============================================================================
module cpeta_pipe #(
    parameter int N  = 16,
    parameter int K  = 11,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  A,
    input  logic [N-1:0]  B,
    input  logic          mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  sum,
    output logic          cout,
    output logic          err_flag,
    input  logic          clr_cnt,
    output logic [CW-1:0] err_cnt
);

    // Stage 1: registered operands and mode
    logic          s1_valid_q;
    logic [N-1:0]  a_q;
    logic [N-1:0]  b_q;
    logic          mode_q;

    // Stage 2: registered result
    logic          out_valid_q;
    logic [N-1:0]  sum_q;
    logic          cout_q;
    logic          err_q;
    logic [CW-1:0] err_cnt_q;

    // Stage-2 next-state values computed from stage 1
    logic [N-1:0]  sum_d;
    logic          cout_d;
    logic          err_d;

    // Intermediate arithmetic
    logic [K-1:0]  apx_low;
    logic          apx_found;
    logic [N-K:0]  apx_high;
    logic          apx_cp;
    logic [N:0]    exact;
    logic [N:0]    approx;

    logic          s2_load;
    logic          out_hs;

    // Stage 2 accepts new contents when empty or when its result leaves now
    assign s2_load  = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_load;
    assign out_hs   = out_valid_q && out_ready;

    // Approximate lower part: XOR above the highest generate position, ones from there down
    always_comb begin
        apx_low   = '0;
        apx_found = 1'b0;
        for (int i = K - 1; i >= 0; i--) begin
            if (apx_found) begin
                apx_low[i] = 1'b1;
            end else if (a_q[i] && b_q[i]) begin
                apx_found  = 1'b1;
                apx_low[i] = 1'b1;
            end else begin
                apx_low[i] = a_q[i] ^ b_q[i];
            end
        end
    end

    // Upper part is exact, seeded by the carry generated at the top lower-part bit
    assign apx_cp   = a_q[K-1] & b_q[K-1];
    assign apx_high = {1'b0, a_q[N-1:K]} + {1'b0, b_q[N-1:K]} + {{(N-K){1'b0}}, apx_cp};
    assign approx   = {apx_high, apx_low};
    assign exact    = {1'b0, a_q} + {1'b0, b_q};

    // Select the result and flag any difference from the exact sum
    always_comb begin
        sum_d  = exact[N-1:0];
        cout_d = exact[N];
        err_d  = 1'b0;
        if (!mode_q) begin
            sum_d  = approx[N-1:0];
            cout_d = approx[N];
            err_d  = (approx != exact);
        end
    end

    // Stage 1 register: captures operands whenever the pipe can take them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            mode_q     <= 1'b0;
        end else if (in_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                a_q    <= A;
                b_q    <= B;
                mode_q <= mode;
            end
        end
    end

    // Stage 2 register: holds the result until downstream takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            err_q       <= 1'b0;
        end else if (s2_load) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
                err_q  <= err_d;
            end
        end
    end

    // Saturating error counter; clear takes priority over an increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (clr_cnt) begin
            err_cnt_q <= '0;
        end else if (out_hs && err_q && (err_cnt_q != {CW{1'b1}})) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign err_flag  = err_q;
    assign err_cnt   = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cpeta_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpeta_pipe
// Description : Scoreboard bench for cpeta_pipe. Two instances share stimulus;
//               one uses a 16-bit error counter, the other a 2-bit counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpeta_pipe;

    typedef struct {
        logic        mode;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] sum;
        logic        cout;
        logic        err;
    } vec_t;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_ready2;
    logic [15:0] A;
    logic [15:0] B;
    logic        mode;
    logic        out_valid;
    logic        out_valid2;
    logic        out_ready;
    logic [15:0] sum;
    logic [15:0] sum2;
    logic        cout;
    logic        cout2;
    logic        err_flag;
    logic        err_flag2;
    logic        clr_cnt;
    logic [15:0] err_cnt;
    logic [1:0]  err_cnt2;

    int   nvec;
    int   nfail;
    int   stalls;
    int   m16;
    int   m2;
    exp_t sb[$];
    vec_t vt[10];

    logic        hold_v;
    logic [15:0] hold_sum;
    logic        hold_cout;
    logic        hold_err;

    cpeta_pipe #(.N(16), .K(11), .CW(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .err_flag(err_flag), .clr_cnt(clr_cnt),
        .err_cnt(err_cnt)
    );

    cpeta_pipe #(.N(16), .K(11), .CW(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .A(A), .B(B), .mode(mode), .out_valid(out_valid2), .out_ready(out_ready),
        .sum(sum2), .cout(cout2), .err_flag(err_flag2), .clr_cnt(clr_cnt),
        .err_cnt(err_cnt2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        nvec++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Drive one transaction, wait (bounded) for acceptance, record its expected result
    task automatic send(input int idx);
        int n;
        exp_t e;
        A        = vt[idx].a;
        B        = vt[idx].b;
        mode     = vt[idx].mode;
        in_valid = 1'b1;
        n        = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 50) begin
                chk("accept timeout", 32'd1, 32'd0);
                break;
            end
        end
        stalls += n;
        e.sum  = vt[idx].sum;
        e.cout = vt[idx].cout;
        e.err  = vt[idx].err;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        chk("drain pending", sb.size(), 0);
    endtask

    // Monitor: compares every delivered result against the scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("held out_valid", {31'd0, out_valid}, 32'd1);
                chk("held sum", {16'd0, sum}, {16'd0, hold_sum});
                chk("held cout", {31'd0, cout}, {31'd0, hold_cout});
                chk("held err_flag", {31'd0, err_flag}, {31'd0, hold_err});
            end
            chk("twin out_valid", {31'd0, out_valid2}, {31'd0, out_valid});
            if (out_valid && out_ready) begin
                chk("err_cnt16", {16'd0, err_cnt}, m16);
                chk("err_cnt2", {30'd0, err_cnt2}, m2);
                if (sb.size() == 0) begin
                    chk("unexpected output", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sum", {16'd0, sum}, {16'd0, e.sum});
                    chk("cout", {31'd0, cout}, {31'd0, e.cout});
                    chk("err_flag", {31'd0, err_flag}, {31'd0, e.err});
                    chk("sum2", {16'd0, sum2}, {16'd0, e.sum});
                    if (e.err) begin
                        if (m16 < 65535) m16++;
                        if (m2 < 3) m2++;
                    end
                end
            end
            if (clr_cnt) begin
                m16 = 0;
                m2  = 0;
            end
            hold_v    = out_valid && !out_ready;
            hold_sum  = sum;
            hold_cout = cout;
            hold_err  = err_flag;
        end
    end

    initial begin
        nvec = 0; nfail = 0; stalls = 0; m16 = 0; m2 = 0;
        hold_v = 1'b0; hold_sum = '0; hold_cout = 1'b0; hold_err = 1'b0;
        //          mode   A         B         sum       cout  err
        vt[0] = '{1'b0, 16'h1234, 16'h5678, 16'h67FF, 1'b0, 1'b1};
        vt[1] = '{1'b0, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b0, 1'b1};
        vt[2] = '{1'b1, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
        vt[3] = '{1'b0, 16'hAAAA, 16'h5555, 16'hFFFF, 1'b0, 1'b0};
        vt[4] = '{1'b1, 16'h1234, 16'h5678, 16'h68AC, 1'b0, 1'b0};
        vt[5] = '{1'b0, 16'h0400, 16'h0400, 16'h0FFF, 1'b0, 1'b1};
        vt[6] = '{1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1};
        vt[7] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vt[8] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b0};
        vt[9] = '{1'b0, 16'h0003, 16'h0001, 16'h0003, 1'b0, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0;
        A = '0; B = '0; mode = 1'b0;
        #3;
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset sum", {16'd0, sum}, 32'd0);
        chk("reset err_cnt", {16'd0, err_cnt}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Latency and first counter increment
        send(0);
        chk("latency s1 out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("latency s2 out_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
        chk("err_cnt after first", {16'd0, err_cnt}, 32'd1);

        // Full-throughput stream of the remaining vectors
        stalls = 0;
        for (int i = 1; i < 10; i++) send(i);
        chk("stream stalls", stalls, 0);
        drain();
        @(posedge clk);
        #1;
        chk("err_cnt16 total", {16'd0, err_cnt}, 32'd5);
        chk("err_cnt2 saturated", {30'd0, err_cnt2}, 32'd3);

        // Clear coinciding with an erroneous delivery
        out_ready = 1'b0;
        send(0);
        for (int i = 0; i < 20; i++) begin
            if (out_valid) break;
            @(negedge clk);
        end
        chk("clr setup out_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        clr_cnt   = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        chk("clr err_cnt16", {16'd0, err_cnt}, 32'd0);
        chk("clr err_cnt2", {30'd0, err_cnt2}, 32'd0);

        // Back-pressure: two accepts then in_ready drops, first result held
        out_ready = 1'b0;
        send(4);
        send(5);
        A = vt[6].a; B = vt[6].b; mode = vt[6].mode; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(6);
        drain();
        @(posedge clk);
        #1;
        chk("stall err_cnt16", {16'd0, err_cnt}, 32'd2);

        // Reset with two transactions in flight
        out_ready = 1'b0;
        send(1);
        send(2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset out_valid", {31'd0, out_valid}, 32'd0);
        chk("midreset in_ready", {31'd0, in_ready}, 32'd1);
        chk("midreset err_cnt16", {16'd0, err_cnt}, 32'd0);
        chk("midreset err_cnt2", {30'd0, err_cnt2}, 32'd0);
        sb.delete();
        m16 = 0;
        m2  = 0;
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (8) @(negedge clk);
        chk("post-reset out_valid", {31'd0, out_valid}, 32'd0);

        // Operation resumes normally after reset
        @(posedge clk);
        #1;
        send(2);
        send(3);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpeta_pipe.md
CPETA_PIPE -- requirements
Module: cpeta_pipe

Interface
REQ-001 Parameter N, default 16, operand/sum width.
REQ-002 Parameter K, default 11, approximate lower-part width; legal range 1 <= K <= N-1.
REQ-003 Parameter CW, default 16, error-counter width.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  operand transfer request.
REQ-007 in_ready  output  1  block accepts operands this cycle.
REQ-008 A, B  input  N each  unsigned operands.
REQ-009 mode  input  1  1 = exact add, 0 = approximate add; sampled with operands.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 sum  output  N  result sum.
REQ-013 cout  output  1  result carry-out.
REQ-014 err_flag  output  1  delivered result differs from exact A+B.
REQ-015 clr_cnt  input  1  synchronous clear of err_cnt.
REQ-016 err_cnt  output  CW  saturating count of erroneous delivered results.

Function
REQ-017 Approximate lower part (bits K-1..0): scan from bit K-1 down; bits above the first position with A[i]&B[i]=1 get A^B; that position and all below get 1; no such position -> all bits A^B.
REQ-018 Approximate upper part (bits N-1..K): exact add of A[N-1:K]+B[N-1:K]+cp, cp = A[K-1]&B[K-1]; its carry-out drives cout.
REQ-019 Exact mode: {cout,sum} = A+B at N+1 bits.
REQ-020 err_flag = ({cout,sum} != A+B); always 0 in exact mode.
REQ-021 Two-stage pipeline: stage 1 registers A, B, mode; stage 2 registers sum, cout, err_flag; latency 2 cycles from input handshake to out_valid with no stall.
REQ-022 Input handshake = in_valid & in_ready; output handshake = out_valid & out_ready.
REQ-023 Stage 2 loads when empty or its contents leave this cycle; stage 1 advances under the same condition.
REQ-024 in_ready = !s1_valid | stage-2-loads; combinational, no dependence on in_valid.
REQ-025 out_valid, sum, cout, err_flag hold stable while out_valid=1 and out_ready=0.
REQ-026 Full throughput: with out_ready held 1, one result per cycle, no bubbles.
REQ-027 Simultaneous accept and deliver in one cycle: both occur, no loss, no duplication.
REQ-028 err_cnt increments by 1 on each output handshake with err_flag=1.
REQ-029 err_cnt saturates at 2^CW-1; no wrap.
REQ-030 clr_cnt=1 sets err_cnt to 0 next cycle; clear wins over simultaneous increment.
REQ-031 mode changes affect only transactions accepted after the change.

Reset
REQ-032 rst_n low: s1_valid, out_valid, sum, cout, err_flag, err_cnt all 0 immediately, independent of clk.
REQ-033 in_ready = 1 during and after reset.
REQ-034 Reset mid-operation: in-flight transactions discarded, no output handshake; counter 0.
REQ-035 First acceptance on first rising edge with rst_n high and in_valid=1.

Verification
REQ-036 mode=0, A=0x1234, B=0x5678, out_ready=1 -> 2 cycles later sum=0x67FF, cout=0, err_flag=1, err_cnt=1.
REQ-037 mode=0, A=0xFFFF, B=0x0001 -> sum=0xFFFF, cout=0, err_flag=1; same operands mode=1 -> sum=0x0000, cout=1, err_flag=0.
REQ-038 mode=0, A=0xAAAA, B=0x5555 -> sum=0xFFFF, cout=0, err_flag=0, err_cnt unchanged.
REQ-039 Back-to-back 3 transactions, out_ready=0 for 4 cycles -> in_ready=0 after 2 accepts, first result held stable; release -> results in order, none lost.
REQ-040 CW=2, 5 erroneous deliveries -> err_cnt=3; clr_cnt asserted with erroneous delivery -> err_cnt=0.
REQ-041 rst_n pulsed low with 2 transactions in flight -> out_valid=0 at once, no results emerge afterward, err_cnt=0.
